lfsr_word_gen: RTL and testbench
================================

// Module: lfsr_word_gen
// PURPOSE
//  Parametrised pseudo-random word source built on a single Galois LFSR with programmable length and taps.
//  Each output word is assembled serially, one LFSR step per clock, so successive bits are sequence-correlated only through the polynomial.
//  Words are delivered on a VALID/READY handshake to SRAM test-pattern and counter-demo logic.
//  Includes seed loading, zero-seed substitution and lock-up recovery.
// PARAMETERS
//  WIDTH         8        output word width in bits (>=1)
//  LFSR_LEN      16       LFSR state width in bits (>=2)
//  TAPS          16'hB400 Galois feedback mask, LFSR_LEN bits (x^16+x^14+x^13+x^11+1, maximal length)
//  DEFAULT_SEED  16'hACE1 state loaded at reset and substituted for a zero seed; must be non-zero
// PORTS
//  CLK        in   1         clock, all state updates on rising edge
//  RST        in   1         asynchronous, active-low reset
//  LOAD_SEED  in   1         load SEED into LFSR this cycle, aborts the word in progress
//  SEED       in   LFSR_LEN  seed value, sampled only when LOAD_SEED=1
//  VAL_READY  in   1         consumer accepts VAL when VAL_VALID=1
//  VAL        out  WIDTH     random word; stable while VAL_VALID=1
//  VAL_VALID  out  1         VAL holds a complete word
//  LOCKUP     out  1         one-cycle pulse: all-zero LFSR state detected and recovered
// BEHAVIOUR
//  Reset (RST=0): lfsr<=DEFAULT_SEED, bit_cnt<=0, VAL<=0, VAL_VALID<=0, LOCKUP<=0, FSM<=FILL.
//  LFSR step (Galois, right shift): out_bit=lfsr[0]; lfsr_next=(lfsr>>1) ^ (lfsr[0] ? TAPS : 0).
//  FSM states FILL and HOLD:
//   FILL: each edge, one step; VAL[bit_cnt]<=out_bit; bit_cnt++.
//         On the edge with bit_cnt==WIDTH-1: bit_cnt<=0, VAL_VALID<=1, FSM->HOLD.
//   HOLD: LFSR frozen; VAL and VAL_VALID held. The edge with VAL_READY=1 completes the transfer:
//         VAL_VALID<=0, FSM->FILL. VAL keeps its old value until overwritten bit by bit.
//  Bit order: the first LFSR output bit of a word lands in VAL[0] (LSB first).
//  Latency: VAL_VALID rises WIDTH edges after reset release, after a LOAD_SEED edge, or after the accepting edge.
//   Throughput: one word per WIDTH+1 cycles with VAL_READY tied high.
//  LOAD_SEED (any state, highest priority):
//   lfsr<=(SEED==0 ? DEFAULT_SEED : SEED); bit_cnt<=0; VAL_VALID<=0; FSM->FILL; no step that edge.
//   The partially built word is discarded.
//  LOAD_SEED together with VAL_VALID&VAL_READY: the transfer still counts as done; the seed load proceeds as above.
//  Lock-up: if lfsr==0 at a FILL edge without LOAD_SEED (bad TAPS only):
//   lfsr<=DEFAULT_SEED, no VAL bit written, bit_cnt unchanged, LOCKUP=1 for that one cycle.
//  VAL_READY is ignored while VAL_VALID=0. SEED is ignored while LOAD_SEED=0.
//  Reset asserted mid-word: immediate return to reset values. The partial word is lost.
//  Width rules: bit_cnt is $clog2(WIDTH) bits, minimum 1. WIDTH > LFSR_LEN is legal: bits keep stepping through the sequence.
// TESTING
//  Reset, then LOAD_SEED=1 SEED=16'hACE1 for 1 cycle, VAL_READY=0
//   -> VAL_VALID rises 8 edges later, VAL=8'hE1, internal lfsr=16'hC2C4; VAL_VALID stays high and VAL stays stable for 20 cycles.
//  Same as above, then VAL_READY=1 for 1 cycle
//   -> VAL_VALID low next cycle, high again 8 edges later; VAL matches the bit-accurate Galois reference model.
//  LOAD_SEED with SEED=0
//   -> identical word stream to LOAD_SEED with SEED=16'hACE1 (first VAL=8'hE1); LOCKUP never pulses.
//  VAL_READY tied high, run 65535*8 steps after a seed load
//   -> exactly one VAL_VALID per 9 cycles; the LFSR state returns to the seed after 65535 steps, never equals 0.
//  LOAD_SEED pulsed at bit_cnt=3 of a word
//   -> no VAL_VALID for that word; the next VAL_VALID comes 8 edges after the load, with VAL = low byte of the new seed.
//  TAPS=16'h0000, SEED=16'h0001
//   -> after 1 step lfsr=0; on the next edge LOCKUP pulses, lfsr=16'hACE1, and bit_cnt does not advance on that edge.

Source files
------------

// File: rtl/lfsr_word_gen.sv
// Pseudo-random word source: one Galois LFSR step per clock fills the output word LSB first,
// and the finished word is offered on a VALID/READY handshake.
module lfsr_word_gen #(
    parameter int unsigned           WIDTH        = 8,
    parameter int unsigned           LFSR_LEN     = 16,
    parameter logic [LFSR_LEN-1:0]   TAPS         = 16'hB400,
    parameter logic [LFSR_LEN-1:0]   DEFAULT_SEED = 16'hACE1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_seed_i,
    input  logic [LFSR_LEN-1:0] seed_i,
    input  logic                val_ready_i,
    output logic [WIDTH-1:0]    val_o,
    output logic                val_valid_o,
    output logic                lockup_o
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t              state_q, state_d;
    logic [LFSR_LEN-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    val_q, val_d;
    logic                valid_q, valid_d;
    logic                lockup_q, lockup_d;
    logic [LFSR_LEN-1:0] lfsr_step;

    assign lfsr_step = {1'b0, lfsr_q[LFSR_LEN-1:1]} ^ (lfsr_q[0] ? TAPS : '0);

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        val_d    = val_q;
        valid_d  = valid_q;
        lockup_d = 1'b0;
        if (load_seed_i) begin
            // Seed load wins over everything; a concurrent handshake still completes.
            lfsr_d  = (seed_i == '0) ? DEFAULT_SEED : seed_i;
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = FILL;
        end else begin
            case (state_q)
                FILL: begin
                    if (lfsr_q == '0) begin
                        lfsr_d   = DEFAULT_SEED;
                        lockup_d = 1'b1;
                    end else begin
                        lfsr_d       = lfsr_step;
                        val_d[cnt_q] = lfsr_q[0];
                        if (cnt_q == LAST_BIT) begin
                            cnt_d   = '0;
                            valid_d = 1'b1;
                            state_d = HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (val_ready_i) begin
                        valid_d = 1'b0;
                        state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= FILL;
            lfsr_q   <= DEFAULT_SEED;
            cnt_q    <= '0;
            val_q    <= '0;
            valid_q  <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            val_q    <= val_d;
            valid_q  <= valid_d;
            lockup_q <= lockup_d;
        end
    end

    assign val_o       = val_q;
    assign val_valid_o = valid_q;
    assign lockup_o    = lockup_q;

endmodule

// File: tb/tb_lfsr_word_gen.sv
// Scoreboard bench for lfsr_word_gen: directed seed/handshake/abort/lock-up cases,
// expected words and arrival cycles queued by the stimulus and checked by monitors.
module tb_lfsr_word_gen;

    typedef struct {
        logic [7:0]  word;
        int unsigned rise;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load, load_z;
    logic [15:0] seed, seed_z;
    logic        ready, ready_z;
    logic [7:0]  val, val_z;
    logic        valid, valid_z;
    logic        lockup, lockup_z;

    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned bad = 0;

    exp_t        sbq[$];
    exp_t        zq[$];
    int unsigned lzq[$];

    lfsr_word_gen #(.WIDTH(8), .LFSR_LEN(16), .TAPS(16'hB400), .DEFAULT_SEED(16'hACE1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .load_seed_i(load), .seed_i(seed),
        .val_ready_i(ready), .val_o(val), .val_valid_o(valid), .lockup_o(lockup)
    );

    // Zero taps force the register to all-zero, exercising lock-up recovery.
    lfsr_word_gen #(.WIDTH(8), .LFSR_LEN(16), .TAPS(16'h0000), .DEFAULT_SEED(16'hACE1)) dut_z (
        .clk_i(clk), .rst_ni(rst_n), .load_seed_i(load_z), .seed_i(seed_z),
        .val_ready_i(ready_z), .val_o(val_z), .val_valid_o(valid_z), .lockup_o(lockup_z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic next_word(inout logic [15:0] s, output logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            w[i] = s[0];
            s = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
        end
    endtask

    // Main DUT monitor
    logic [7:0] cur_exp;
    logic       prev_v = 1'b0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (valid && !prev_v) begin
                if (sbq.size() == 0) begin
                    check("unexpected_word", {24'd0, val}, 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    check("word", {24'd0, val}, {24'd0, e.word});
                    check("latency", cyc, e.rise);
                    cur_exp = e.word;
                end
            end else if (valid) begin
                check("hold_stable", {24'd0, val}, {24'd0, cur_exp});
            end
            if (lockup) check("lockup_dut", {31'd0, lockup}, 32'd0);
            prev_v = valid;
        end else begin
            prev_v = 1'b0;
        end
    end

    // Zero-tap DUT monitor
    logic prev_vz = 1'b0;
    always @(posedge clk) begin
        exp_t e;
        int unsigned lc;
        #1;
        if (rst_n) begin
            if (valid_z && !prev_vz) begin
                if (zq.size() == 0) begin
                    check("unexpected_word_z", {24'd0, val_z}, 32'hFFFF_FFFF);
                end else begin
                    e = zq.pop_front();
                    check("word_z", {24'd0, val_z}, {24'd0, e.word});
                    check("latency_z", cyc, e.rise);
                end
            end
            if (lockup_z) begin
                if (lzq.size() == 0) begin
                    check("unexpected_lockup_z", cyc, 32'hFFFF_FFFF);
                end else begin
                    lc = lzq.pop_front();
                    check("lockup_cycle_z", cyc, lc);
                end
            end
            prev_vz = valid_z;
        end else begin
            prev_vz = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] st;
        logic [7:0]  w;
        int unsigned c0;
        int unsigned budget;

        rst_n = 1'b0; load = 1'b0; seed = '0; ready = 1'b0;
        load_z = 1'b0; seed_z = '0; ready_z = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_val", {24'd0, val}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_lockup", {31'd0, lockup}, 32'd0);
        check("rst_val_z", {24'd0, val_z}, 32'd0);
        check("rst_valid_z", {31'd0, valid_z}, 32'd0);

        // Reset release: first word from DEFAULT_SEED after 8 edges
        rst_n = 1'b1;
        sbq.push_back('{8'hE1, cyc + 8});
        zq.push_back('{8'hE1, cyc + 8});
        repeat (30) @(negedge clk);

        // Explicit seed load while holding; word must stay stable with ready low
        load = 1'b1; seed = 16'hACE1;
        sbq.push_back('{8'hE1, cyc + 9});
        @(negedge clk);
        load = 1'b0; seed = 16'h0000;
        repeat (28) @(negedge clk);

        // Single ready pulse: valid drops, next word 0xC4 follows 8 edges after acceptance
        ready = 1'b1;
        sbq.push_back('{8'hC4, cyc + 9});
        @(negedge clk);
        ready = 1'b0;
        check("valid_drop", {31'd0, valid}, 32'd0);
        repeat (15) @(negedge clk);

        // Third word from the reference sequence
        st = 16'hACE1;
        next_word(st, w);
        next_word(st, w);
        next_word(st, w);
        ready = 1'b1;
        sbq.push_back('{w, cyc + 9});
        @(negedge clk);
        ready = 1'b0;
        repeat (15) @(negedge clk);

        // Zero seed substitutes DEFAULT_SEED
        load = 1'b1; seed = 16'h0000;
        sbq.push_back('{8'hE1, cyc + 9});
        @(negedge clk);
        load = 1'b0;
        repeat (15) @(negedge clk);

        // Abort: accept, fill 3 bits, then reload; partial word never appears
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (3) @(negedge clk);
        load = 1'b1; seed = 16'h5A3C;
        sbq.push_back('{8'h3C, cyc + 9});
        @(negedge clk);
        load = 1'b0; seed = 16'h0000;
        repeat (15) @(negedge clk);

        // Lock-up on zero-tap instance: seed 1 empties after one step
        load_z = 1'b1; seed_z = 16'h0001;
        lzq.push_back(cyc + 3);
        zq.push_back('{8'hC3, cyc + 10});
        @(negedge clk);
        load_z = 1'b0; seed_z = 16'h0000;
        repeat (15) @(negedge clk);

        // Ready tied high: one word per 9 cycles following the reference sequence
        load = 1'b1; seed = 16'hACE1; ready = 1'b1;
        c0 = cyc;
        st = 16'hACE1;
        for (int k = 0; k < 1000; k++) begin
            next_word(st, w);
            sbq.push_back('{w, c0 + 9 + 9 * k});
        end
        @(negedge clk);
        load = 1'b0; seed = 16'h0000;

        budget = 0;
        while (sbq.size() != 0 && budget < 12000) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        check("drain_sbq", sbq.size(), 32'd0);
        check("drain_zq", zq.size(), 32'd0);
        check("drain_lzq", lzq.size(), 32'd0);

        // Reset asserted mid-word returns outputs to reset values
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midword_rst_valid", {31'd0, valid}, 32'd0);
        check("midword_rst_val", {24'd0, val}, 32'd0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
